frame_tick_rx: RTL and testbench



---
 rtl/frame_tick_rx_pkg.sv | 17 +
 rtl/frame_tick_rx_if.sv | 23 ++
 rtl/frame_tick_rx_edge_sync.sv | 24 ++
 rtl/frame_tick_rx.sv | 145 ++++++++++++++
 tb/tb_frame_tick_rx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/frame_tick_rx_pkg.sv
// Shared types and default constants for the frame-clock receiver.
// Optional feature macro FRAME_TICK_GATE_EN is consumed by frame_tick_rx.sv.
package frame_tick_pkg;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_LOST    = 2'd2
    } state_t;

    localparam int DEF_NOM_PERIOD = 16667;
    localparam int DEF_TOL        = 512;
    localparam int DEF_LOCK_COUNT = 4;
    localparam int DEF_CNT_W      = 21;
    localparam int FRAME_CNT_W    = 16;

endpackage

// File: rtl/frame_tick_rx_if.sv
// Control/status bundle between the frame-clock receiver and game logic.
interface frame_tick_rx_if #(
    parameter int CNT_W = frame_tick_pkg::DEF_CNT_W
);
    logic                                   slow_clk_in;
    logic                                   enable;
    logic                                   clr_lost;
    logic                                   frame_tick;
    logic [frame_tick_pkg::FRAME_CNT_W-1:0] frame_count;
    logic [CNT_W-1:0]                       period_cycles;
    logic                                   locked;
    logic                                   lost;

    modport master (
        output slow_clk_in, enable, clr_lost,
        input  frame_tick, frame_count, period_cycles, locked, lost
    );

    modport slave (
        input  slow_clk_in, enable, clr_lost,
        output frame_tick, frame_count, period_cycles, locked, lost
    );
endinterface

// File: rtl/frame_tick_rx_edge_sync.sv
// Synchronizer chain for the slow frame clock plus rising-edge detector.
module edge_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/frame_tick_rx.sv
// Frame-clock receiver: frame_tick pulses, period measurement, lock/loss tracking.
// Define FRAME_TICK_GATE_EN to suppress frame_tick until the input is locked.
module frame_tick_rx
    import frame_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NOM_PERIOD  = DEF_NOM_PERIOD,
    parameter int TOL         = DEF_TOL,
    parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    frame_tick_rx_if.slave  bus
);
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic in_tol(input logic [CNT_W-1:0] meas);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, meas}) - $signed((CNT_W+1)'(NOM_PERIOD));
        if (diff < 0) diff = -diff;
        return diff <= $signed((CNT_W+1)'(TOL));
    endfunction

    logic                   w_rise;
    logic [CNT_W-1:0]       w_meas;
    logic                   w_meas_vld;
    logic                   w_in_tol;
    logic                   w_timeout;
    logic                   w_lose;
    logic                   w_fire;

    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_period;
    logic                   r_have_edge;
    state_t                 r_state;
    logic [GOOD_W-1:0]      r_good;
    logic                   r_locked;
    logic                   r_lost;
    logic                   r_tick;
    logic [FRAME_CNT_W-1:0] r_frame_count;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (bus.slow_clk_in),
        .o_rise  (w_rise)
    );

    assign w_meas     = sat_inc(r_cnt);
    assign w_meas_vld = w_rise & r_have_edge;
    assign w_in_tol   = in_tol(w_meas);
    assign w_timeout  = r_cnt > CNT_W'(NOM_PERIOD + TOL);
    assign w_lose     = bus.enable && (r_state == ST_LOCKED) &&
                        ((w_meas_vld && !w_in_tol) || (!w_rise && w_timeout));

`ifdef FRAME_TICK_GATE_EN
    assign w_fire = bus.enable & w_rise & r_locked;
`else
    assign w_fire = bus.enable & w_rise;
`endif

    // Measurement path runs regardless of enable so period_cycles stays live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_period    <= '0;
            r_have_edge <= 1'b0;
        end else if (w_rise) begin
            r_cnt       <= '0;
            r_have_edge <= 1'b1;
            if (r_have_edge) r_period <= w_meas;
        end else begin
            r_cnt <= sat_inc(r_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_ACQUIRE;
            r_good        <= '0;
            r_locked      <= 1'b0;
            r_lost        <= 1'b0;
            r_tick        <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_tick <= w_fire;
            if (w_fire) r_frame_count <= r_frame_count + FRAME_CNT_W'(1);

            // A loss in the same cycle as clr_lost must not be missed.
            if (w_lose)            r_lost <= 1'b1;
            else if (bus.clr_lost) r_lost <= 1'b0;

            if (!bus.enable) begin
                r_state  <= ST_ACQUIRE;
                r_good   <= '0;
                r_locked <= 1'b0;
            end else begin
                case (r_state)
                    ST_ACQUIRE: begin
                        if (w_meas_vld) begin
                            if (!w_in_tol) begin
                                r_good <= '0;
                            end else if (r_good == GOOD_W'(LOCK_COUNT - 1)) begin
                                r_good   <= '0;
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                            end else begin
                                r_good <= r_good + GOOD_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (w_lose) begin
                            r_state  <= ST_LOST;
                            r_locked <= 1'b0;
                        end
                    end
                    ST_LOST: begin
                        // The recovering edge only restarts measurement.
                        if (w_rise) begin
                            r_state <= ST_ACQUIRE;
                            r_good  <= '0;
                        end
                    end
                    default: begin
                        r_state  <= ST_ACQUIRE;
                        r_good   <= '0;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.frame_tick    = r_tick;
    assign bus.frame_count   = r_frame_count;
    assign bus.period_cycles = r_period;
    assign bus.locked        = r_locked;
    assign bus.lost          = r_lost;
endmodule

// File: tb/tb_frame_tick_rx.sv
// Directed bench for frame_tick_rx with NOM_PERIOD=100, TOL=5, LOCK_COUNT=4.
module tb_frame_tick_rx;
    localparam int CNT_W = 21;
`ifdef FRAME_TICK_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_ticks  = 0;
    int   t0;

    frame_tick_rx_if #(.CNT_W(CNT_W)) bus();

    frame_tick_rx #(
        .SYNC_STAGES (2),
        .NOM_PERIOD  (100),
        .TOL         (5),
        .LOCK_COUNT  (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.frame_tick) n_ticks <= n_ticks + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.slow_clk_in  = 1'b0;
        bus.enable       = 1'b1;
        bus.clr_lost     = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
    endtask

    // Rising edge now; returns 3 cycles later, when its tick/state update is visible.
    task automatic rise_and_settle();
        bus.slow_clk_in = 1'b1;
        cyc(3);
    endtask

    task automatic rest_of(input int p);
        cyc(p / 2 - 3);
        bus.slow_clk_in = 1'b0;
        cyc(p - p / 2);
    endtask

    task automatic period(input int p);
        rise_and_settle();
        rest_of(p);
    endtask

    initial begin
        bus.slow_clk_in = 1'b0;
        bus.enable      = 1'b1;
        bus.clr_lost    = 1'b0;

        // Reset held with input toggling
        repeat (10) begin
            @(negedge clk);
            bus.slow_clk_in = ~bus.slow_clk_in;
        end
        check_val("rst_tick",   32'(bus.frame_tick),    32'd0);
        check_val("rst_count",  32'(bus.frame_count),   32'd0);
        check_val("rst_period", 32'(bus.period_cycles), 32'd0);
        check_val("rst_locked", 32'(bus.locked),        32'd0);
        check_val("rst_lost",   32'(bus.lost),          32'd0);

        rst_n           = 1'b1;
        bus.slow_clk_in = 1'b0;
        cyc(2);
        bus.slow_clk_in = 1'b1;
        cyc(2);
        check_val("first_tick_early", 32'(bus.frame_tick), 32'd0);
        cyc(1);
        check_val("first_tick",       32'(bus.frame_tick),    GATED ? 32'd0 : 32'd1);
        check_val("first_count",      32'(bus.frame_count),   GATED ? 32'd0 : 32'd1);
        check_val("first_period",     32'(bus.period_cycles), 32'd0);
        cyc(1);
        check_val("tick_one_cycle",   32'(bus.frame_tick),    32'd0);
        cyc(46);
        bus.slow_clk_in = 1'b0;
        cyc(50);
        rise_and_settle();
        check_val("second_period",    32'(bus.period_cycles), 32'd100);
        check_val("second_count",     32'(bus.frame_count),   GATED ? 32'd0 : 32'd2);

        // Lock with periods 100,103,97,100
        do_reset();
        period(100);
        period(103);
        period(97);
        rise_and_settle();
        check_val("lockA_pre_locked", 32'(bus.locked),        32'd0);
        check_val("lockA_period97",   32'(bus.period_cycles), 32'd97);
        rest_of(100);
        bus.slow_clk_in = 1'b1;
        cyc(2);
        check_val("lockA_edge_locked", 32'(bus.locked), 32'd0);
        cyc(1);
        check_val("lockA_locked",     32'(bus.locked),        32'd1);
        check_val("lockA_tick5",      32'(bus.frame_tick),    GATED ? 32'd0 : 32'd1);
        check_val("lockA_count",      32'(bus.frame_count),   GATED ? 32'd0 : 32'd5);

        // Bad period in the middle restarts the good count
        do_reset();
        period(100);
        period(120);
        period(100);
        period(100);
        period(100);
        rise_and_settle();
        check_val("lockB_pre_locked", 32'(bus.locked), 32'd0);
        rest_of(100);
        rise_and_settle();
        check_val("lockB_locked",     32'(bus.locked),        32'd1);
        check_val("lockB_period",     32'(bus.period_cycles), 32'd100);

        // Timeout: input stops while locked
        bus.slow_clk_in = 1'b0;
        cyc(106);
        check_val("to_pre_lost",   32'(bus.lost),   32'd0);
        check_val("to_pre_locked", 32'(bus.locked), 32'd1);
        cyc(1);
        check_val("to_lost",       32'(bus.lost),          32'd1);
        check_val("to_locked",     32'(bus.locked),        32'd0);
        check_val("to_period",     32'(bus.period_cycles), 32'd100);
        bus.clr_lost = 1'b1;
        cyc(1);
        bus.clr_lost = 1'b0;
        check_val("clr_lost",      32'(bus.lost), 32'd0);

        // Relock after LOST, then a loss coinciding with clr_lost
        period(100);
        period(100);
        period(100);
        period(100);
        rise_and_settle();
        check_val("relock_locked", 32'(bus.locked),        32'd1);
        check_val("relock_period", 32'(bus.period_cycles), 32'd100);
        bus.slow_clk_in = 1'b0;
        cyc(106);
        bus.clr_lost = 1'b1;
        cyc(1);
        bus.clr_lost = 1'b0;
        check_val("set_wins_lost",   32'(bus.lost),   32'd1);
        check_val("set_wins_locked", 32'(bus.locked), 32'd0);

        // Enable dropped for three periods
        do_reset();
        period(100);
        period(100);
        period(100);
        period(100);
        rise_and_settle();
        check_val("en_locked",     32'(bus.locked),      32'd1);
        check_val("en_count",      32'(bus.frame_count), GATED ? 32'd0 : 32'd5);
        bus.enable = 1'b0;
        cyc(1);
        check_val("dis_locked",    32'(bus.locked), 32'd0);
        t0 = n_ticks;
        rest_of(99);
        period(110);
        period(95);
        rise_and_settle();
        cyc(1);
        check_val("dis_no_ticks",  n_ticks - t0,            32'd0);
        check_val("dis_count",     32'(bus.frame_count),    GATED ? 32'd0 : 32'd5);
        check_val("dis_locked2",   32'(bus.locked),         32'd0);
        check_val("dis_period",    32'(bus.period_cycles),  32'd95);
        bus.enable = 1'b1;
        rest_of(99);
        period(100);
        period(100);
        rise_and_settle();
        check_val("reen_pre_locked", 32'(bus.locked), 32'd0);
        rest_of(100);
        rise_and_settle();
        check_val("reen_locked",   32'(bus.locked),      32'd1);
        check_val("reen_count",    32'(bus.frame_count), GATED ? 32'd0 : 32'd9);
        rest_of(100);
        rise_and_settle();
        check_val("post_lock_count", 32'(bus.frame_count), GATED ? 32'd1 : 32'd10);
        check_val("post_lock_tick",  32'(bus.frame_tick),  32'd1);

        // frame_count wrap
        force dut.r_frame_count = 16'hFFFF;
        cyc(1);
        release dut.r_frame_count;
        rest_of(99);
        rise_and_settle();
        check_val("wrap_tick",  32'(bus.frame_tick),  32'd1);
        check_val("wrap_count", 32'(bus.frame_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
